johnson_decoder: RTL and testbench

- Receive-side companion to the team's Johnson counter: samples an N-bit Johnson-coded bus and decodes it to a binary count and a one-hot state vector.
- Flags illegal codes and checks that successive samples advance by exactly one step (mod 2N).
- Reports lock status and a saturating error count.
- Used wherever a Johnson counter state must be consumed or monitored by downstream logic.

---
 rtl/johnson_pkg.sv | 19 +
 rtl/johnson_code_decode.sv | 16 +
 rtl/johnson_decoder.sv | 84 ++++++++
 tb/tb_johnson_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg: shared FSM type, default parameters and Johnson-code helpers
package johnson_pkg;
   typedef enum logic [1:0] {HUNT, TRACK, LOCKED} jd_state_e;
   localparam int N_DEF = 4;
   localparam int LOCK_CNT_DEF = 3;
   // every legal Johnson code has at most one adjacent-bit transition
   function automatic logic jc_legal(input logic [31:0] code, input int n);
      int t;
      t = 0;
      for (int i = 0; i < n - 1; i++) t += int'(code[i] ^ code[i+1]);
      return t <= 1;
   endfunction
   function automatic int jc_to_bin(input logic [31:0] code, input int n);
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(code[i]);
      return (code[n-1] || ones == 0) ? ones : 2 * n - ones;
   endfunction
endpackage

// File: rtl/johnson_code_decode.sv
// johnson_code_decode: combinational Johnson code to legal flag, index and one-hot
module johnson_code_decode import johnson_pkg::*; #(
   parameter int N = N_DEF
) (
   input  logic [N-1:0]           code_i,
   output logic                   legal_o,
   output logic [$clog2(2*N)-1:0] count_o,
   output logic [2*N-1:0]         onehot_o
);
   localparam int CW = $clog2(2*N);
   always_comb begin
      legal_o  = jc_legal(32'(code_i), N);
      count_o  = legal_o ? CW'(jc_to_bin(32'(code_i), N)) : '0;
      onehot_o = legal_o ? (2*N)'(1) << count_o : '0;
   end
endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: two-stage Johnson bus decoder with sequence lock checker
module johnson_decoder import johnson_pkg::*; #(
   parameter int N        = N_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF,
   parameter int ERR_W    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           jc_in,
   input  logic                   sample_vld,
   input  logic                   err_clr,
   output logic                   out_vld,
   output logic [$clog2(2*N)-1:0] count,
   output logic [2*N-1:0]         onehot,
   output logic                   code_err,
   output logic                   seq_err,
   output logic                   locked,
   output logic [ERR_W-1:0]       err_cnt
);
   localparam int CW = $clog2(2*N);
   localparam int MW = $clog2(LOCK_CNT + 1);
   logic [N-1:0]   jc_q;
   logic           vld_q;
   logic           legal;
   logic           step;
   logic           brk;
   logic [CW-1:0]  dec_cnt;
   logic [CW-1:0]  ref_q;
   logic [CW-1:0]  ref_inc;
   logic [2*N-1:0] dec_oh;
   logic [MW-1:0]  match_q;
   logic [MW-1:0]  match_d;
   jd_state_e      state_q;
   jd_state_e      state_d;
   johnson_code_decode #(.N(N)) u_dec (
      .code_i   (jc_q),
      .legal_o  (legal),
      .count_o  (dec_cnt),
      .onehot_o (dec_oh)
   );
   always_comb begin
      ref_inc = (ref_q == CW'(2*N-1)) ? '0 : ref_q + 1'b1;
      step    = legal && dec_cnt == ref_inc;
      brk     = vld_q && state_q == LOCKED && !step;
      match_d = !vld_q ? match_q : (state_q == TRACK && step) ? match_q + 1'b1 : '0;
      state_d = !vld_q ? state_q :
                !legal ? HUNT :
                state_q == HUNT ? TRACK :
                !step ? (state_q == TRACK ? TRACK : HUNT) :
                (state_q == LOCKED || int'(match_q) + 1 == LOCK_CNT) ? LOCKED : TRACK;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         jc_q     <= '0;
         vld_q    <= 1'b0;
         out_vld  <= 1'b0;
         count    <= '0;
         onehot   <= '0;
         code_err <= 1'b0;
         seq_err  <= 1'b0;
         locked   <= 1'b0;
         err_cnt  <= '0;
         ref_q    <= '0;
         match_q  <= '0;
         state_q  <= HUNT;
      end else begin
         jc_q     <= jc_in;
         vld_q    <= sample_vld;
         out_vld  <= vld_q;
         code_err <= vld_q && !legal;
         seq_err  <= brk;
         locked   <= state_d == LOCKED;
         state_q  <= state_d;
         match_q  <= match_d;
         err_cnt  <= err_clr ? '0 : (brk && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
         if (vld_q) begin
            count  <= dec_cnt;
            onehot <= dec_oh;
         end
         // an illegal code never becomes the reference
         if (vld_q && legal) ref_q <= dec_cnt;
      end
   end
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: table, directed and random checks against a rule-level model
module tb_johnson_decoder;
   localparam int N = 4;
   localparam int L = 2 * N;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic sample_vld = 1'b0;
   logic err_clr = 1'b0;
   logic [N-1:0] jc_in = '0;
   logic a_vld, b_vld, a_ce, b_ce, a_se, b_se, a_lk, b_lk;
   logic [2:0] a_cnt, b_cnt;
   logic [7:0] a_oh, b_oh;
   logic [7:0] a_err;
   logic [1:0] b_err;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   johnson_decoder dut_a (
      .clk(clk), .reset(reset), .jc_in(jc_in), .sample_vld(sample_vld), .err_clr(err_clr),
      .out_vld(a_vld), .count(a_cnt), .onehot(a_oh), .code_err(a_ce), .seq_err(a_se),
      .locked(a_lk), .err_cnt(a_err)
   );
   johnson_decoder #(.ERR_W(2)) dut_b (
      .clk(clk), .reset(reset), .jc_in(jc_in), .sample_vld(sample_vld), .err_clr(err_clr),
      .out_vld(b_vld), .count(b_cnt), .onehot(b_oh), .code_err(b_ce), .seq_err(b_se),
      .locked(b_lk), .err_cnt(b_err)
   );
   // reference: legal-code table, FSM as integer state 0=hunt 1=track 2=locked
   logic [N-1:0] tab [L];
   int ms, mref, mmatch, werr, nerr, e_cnt, e_oh;
   bit e_vld, e_ce, e_se, e_lk, s1v;
   logic [N-1:0] s1c;
   typedef struct {logic [N-1:0] jc; int cnt; int oh; bit ce; bit se; bit lk; int err;} vec_t;
   vec_t tbl [30];
   function automatic vec_t mk(input logic [N-1:0] jc, input int cnt, input int oh,
                               input bit ce, input bit se, input bit lk, input int err);
      vec_t v;
      v.jc = jc; v.cnt = cnt; v.oh = oh; v.ce = ce; v.se = se; v.lk = lk; v.err = err;
      return v;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      ms = 0; mref = 0; mmatch = 0; werr = 0; nerr = 0; e_cnt = 0; e_oh = 0;
      e_vld = 0; e_ce = 0; e_se = 0; e_lk = 0; s1v = 0; s1c = '0;
   endtask
   task automatic model_edge(input logic [N-1:0] jc, input bit v, input bit clr);
      int k;
      bit ok, step, se;
      se = 0;
      e_vld = s1v;
      e_ce = 0;
      if (s1v) begin
         k = -1;
         for (int i = 0; i < L; i++) if (tab[i] == s1c) k = i;
         ok = k >= 0;
         e_cnt = ok ? k : 0;
         e_oh = ok ? (1 << k) : 0;
         e_ce = !ok;
         step = ok && k == (mref + 1) % L;
         if (ms == 0) begin
            if (ok) begin ms = 1; mmatch = 0; end
         end else if (ms == 1) begin
            if (!ok) ms = 0;
            else if (step) begin
               mmatch++;
               if (mmatch == 3) ms = 2;
            end else mmatch = 0;
         end else if (!step) begin
            se = 1;
            ms = 0;
         end
         if (ok) mref = k;
      end
      e_se = se;
      e_lk = ms == 2;
      werr = clr ? 0 : (se && werr < 255) ? werr + 1 : werr;
      nerr = clr ? 0 : (se && nerr < 3) ? nerr + 1 : nerr;
      s1v = v;
      s1c = jc;
   endtask
   task automatic check_all();
      chk("out_vld", a_vld, e_vld); chk("count", a_cnt, e_cnt); chk("onehot", a_oh, e_oh);
      chk("code_err", a_ce, e_ce); chk("seq_err", a_se, e_se); chk("locked", a_lk, e_lk);
      chk("err_cnt", a_err, werr); chk("err_cnt_w2", b_err, nerr);
      chk("out_vld_w2", b_vld, e_vld); chk("count_w2", b_cnt, e_cnt); chk("onehot_w2", b_oh, e_oh);
      chk("code_err_w2", b_ce, e_ce); chk("seq_err_w2", b_se, e_se); chk("locked_w2", b_lk, e_lk);
   endtask
   task automatic cyc(input logic [N-1:0] jc, input bit v, input bit clr);
      @(negedge clk);
      jc_in = jc; sample_vld = v; err_clr = clr;
      @(posedge clk);
      model_edge(jc, v, clr);
      #1 check_all();
   endtask
   task automatic lock_break(input bit clr_on_break);
      cyc(4'b1100, 1, 0); cyc(4'b1110, 1, 0); cyc(4'b1111, 1, 0); cyc(4'b0111, 1, 0);
      cyc(4'b0111, 1, 0);
      cyc(4'b0000, 0, clr_on_break);
      chk("break_seq_err", a_se, 1);
      chk("break_locked", a_lk, 0);
   endtask
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
   initial begin
      for (int k = 0; k < L; k++)
         tab[k] = k <= N ? N'(((1 << k) - 1) << (N - k)) : N'((1 << (L - k)) - 1);
      tbl[0]  = mk(4'b0000, 0, 'h01, 0, 0, 0, 0);
      tbl[1]  = mk(4'b1000, 1, 'h02, 0, 0, 0, 0);
      tbl[2]  = mk(4'b1100, 2, 'h04, 0, 0, 0, 0);
      tbl[3]  = mk(4'b1110, 3, 'h08, 0, 0, 1, 0);
      tbl[4]  = mk(4'b1111, 4, 'h10, 0, 0, 1, 0);
      tbl[5]  = mk(4'b0111, 5, 'h20, 0, 0, 1, 0);
      tbl[6]  = mk(4'b0011, 6, 'h40, 0, 0, 1, 0);
      tbl[7]  = mk(4'b0001, 7, 'h80, 0, 0, 1, 0);
      tbl[8]  = mk(4'b0000, 0, 'h01, 0, 0, 1, 0);
      tbl[9]  = mk(4'b1000, 1, 'h02, 0, 0, 1, 0);
      tbl[10] = mk(4'b1010, 0, 'h00, 1, 1, 0, 1);
      tbl[11] = mk(4'b1100, 2, 'h04, 0, 0, 0, 1);
      tbl[12] = mk(4'b1110, 3, 'h08, 0, 0, 0, 1);
      tbl[13] = mk(4'b1111, 4, 'h10, 0, 0, 0, 1);
      tbl[14] = mk(4'b0111, 5, 'h20, 0, 0, 1, 1);
      tbl[15] = mk(4'b0011, 6, 'h40, 0, 0, 1, 1);
      tbl[16] = mk(4'b0001, 7, 'h80, 0, 0, 1, 1);
      tbl[17] = mk(4'b0000, 0, 'h01, 0, 0, 1, 1);
      tbl[18] = mk(4'b1000, 1, 'h02, 0, 0, 1, 1);
      tbl[19] = mk(4'b1100, 2, 'h04, 0, 0, 1, 1);
      tbl[20] = mk(4'b1100, 2, 'h04, 0, 1, 0, 2);
      tbl[21] = mk(4'b1110, 3, 'h08, 0, 0, 0, 2);
      tbl[22] = mk(4'b1111, 4, 'h10, 0, 0, 0, 2);
      tbl[23] = mk(4'b0111, 5, 'h20, 0, 0, 0, 2);
      tbl[24] = mk(4'b0011, 6, 'h40, 0, 0, 1, 2);
      tbl[25] = mk(4'b0001, 7, 'h80, 0, 0, 1, 2);
      tbl[26] = mk(4'b0000, 0, 'h01, 0, 0, 1, 2);
      tbl[27] = mk(4'b1000, 1, 'h02, 0, 0, 1, 2);
      tbl[28] = mk(4'b1100, 2, 'h04, 0, 0, 1, 2);
      tbl[29] = mk(4'b1111, 4, 'h10, 0, 1, 0, 3);
      model_reset();
      repeat (2) @(negedge clk);
      #1 check_all();
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i <= 30; i++) begin
         if (i < 30) cyc(tbl[i].jc, 1, 0);
         else cyc('0, 0, 0);
         if (i > 0) begin
            chk("tbl_vld", a_vld, 1);
            chk("tbl_count", a_cnt, tbl[i-1].cnt);
            chk("tbl_onehot", a_oh, tbl[i-1].oh);
            chk("tbl_code_err", a_ce, tbl[i-1].ce);
            chk("tbl_seq_err", a_se, tbl[i-1].se);
            chk("tbl_locked", a_lk, tbl[i-1].lk);
            chk("tbl_err_cnt", a_err, tbl[i-1].err);
         end
      end
      cyc('0, 0, 0);
      chk("idle_vld", a_vld, 0);
      chk("idle_hold_count", a_cnt, 4);
      for (int i = 0; i < 3; i++) lock_break(0);
      chk("err_wide", a_err, 6);
      chk("err_sat_w2", b_err, 3);
      lock_break(1);
      chk("clr_prio", a_err, 0);
      chk("clr_prio_w2", b_err, 0);
      cyc(4'b0000, 1, 0); cyc(4'b1000, 1, 0); cyc(4'b1100, 1, 0); cyc(4'b1110, 1, 0);
      cyc(4'b1111, 1, 0); cyc(4'b0111, 1, 0);
      chk("pre_reset_locked", a_lk, 1);
      @(negedge clk) reset = 1'b0;
      #1 model_reset();
      check_all();
      chk("async_rst_vld", a_vld, 0);
      @(posedge clk);
      #1 check_all();
      @(negedge clk);
      reset = 1'b1;
      sample_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc('0, 0, 0);
         chk("post_rst_vld", a_vld, 0);
      end
      begin
         int last;
         last = 0;
         for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] c;
            bit v;
            int r;
            v = $urandom_range(0, 9) < 7;
            r = $urandom_range(0, 19);
            c = r < 15 ? tab[(last + 1) % L] : r < 17 ? tab[last] :
                r < 19 ? tab[$urandom_range(0, L - 1)] : N'($urandom);
            if (v) for (int k = 0; k < L; k++) if (tab[k] == c) last = k;
            cyc(c, v, $urandom_range(0, 49) == 0);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
